// File: rtl/scan_mux.sv
// scan_mux: N-channel, W-bit registered multiplexer with per-channel valid/ready
// handshaking, a registered output stage that honours backpressure, and two
// select modes (manual index or round-robin scan across valid channels).
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_data   flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid  per-channel data-valid
//   in_ready  per-channel accept strobe (combinational, at most one bit high)
//   mode      0 = manual select, 1 = round-robin scan
//   sel       channel index used in manual mode
//   o_data    registered selected data
//   o_chan    registered index of the channel that supplied o_data
//   o_valid   o_data/o_chan hold a valid beat
//   o_ready   consumer accepts the current beat
module scan_mux #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          o_data,
  output logic [SEL_W-1:0]          o_chan,
  output logic                      o_valid,
  input  logic                      o_ready
);

  logic             load;
  logic             sel_ok;
  logic             rr_hit;
  logic             grant;
  logic [SEL_W-1:0] rr_q;
  logic [SEL_W-1:0] rr_g;
  logic [SEL_W-1:0] gnt_ch;
  logic [SEL_W-1:0] rr_next;
  logic [SEL_W:0]   rr_sum;
  logic [WIDTH-1:0] gnt_data;

  always_comb begin
    load   = !o_valid || o_ready;
    // Extra bit keeps the compare meaningful when CHANNELS is not a power of 2.
    sel_ok = {1'b0, sel} < (SEL_W + 1)'(CHANNELS);

    // Round-robin: first valid channel at or after rr_q, wrapping at CHANNELS-1.
    rr_hit = 1'b0;
    rr_g   = '0;
    rr_sum = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      rr_sum = {1'b0, rr_q} + (SEL_W + 1)'(i);
      if (rr_sum >= (SEL_W + 1)'(CHANNELS)) begin
        rr_sum = rr_sum - (SEL_W + 1)'(CHANNELS);
      end
      if (!rr_hit && in_valid[rr_sum[SEL_W-1:0]]) begin
        rr_hit = 1'b1;
        rr_g   = rr_sum[SEL_W-1:0];
      end
    end

    if (mode) begin
      gnt_ch = rr_g;
      grant  = load && rr_hit;
    end else begin
      gnt_ch = sel;
      grant  = load && sel_ok && in_valid[sel];
    end

    gnt_data = in_data[gnt_ch*WIDTH +: WIDTH];
    rr_next  = (gnt_ch == SEL_W'(CHANNELS - 1)) ? '0 : gnt_ch + 1'b1;

    // Held at zero during reset so no source sees an accept that is then lost.
    for (int k = 0; k < int'(CHANNELS); k++) begin
      in_ready[k] = rst_n && grant && (gnt_ch == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data  <= '0;
      o_chan  <= '0;
      o_valid <= 1'b0;
      rr_q    <= '0;
    end else if (load) begin
      if (grant) begin
        o_data  <= gnt_data;
        o_chan  <= gnt_ch;
        o_valid <= 1'b1;
        if (mode) begin
          rr_q <= rr_next;
        end
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
